// File: rtl/rc_pkg.sv
// Shared encodings for the ring counter generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents: mode encodings (MODE_*) and shift-direction encodings (DIR_*).
package rc_pkg;

  // Runtime mode select
  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_SHIFT   = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  // Shift direction
  localparam logic DIR_LEFT  = 1'b0;  // toward MSB
  localparam logic DIR_RIGHT = 1'b1;  // toward LSB

endpackage

// File: rtl/ring_counter_gen_onehot_chk.sv
// One-hot detector: flags a vector with exactly one bit set.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   value     in  WIDTH  vector under test
//   is_onehot out 1      1 when exactly one bit of value is set (0 for all-zero)
module onehot_chk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic             is_onehot
);

  // Clearing the lowest set bit leaves zero only for power-of-two values.
  always_comb begin
    is_onehot = (value != '0) && ((value & (value - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/ring_counter_gen.sv
// Ring / Johnson / shift-fill sequencer with step enable, load and terminal-count pulse.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; en=0 freezes the register, init > load > en priority.
//
// Ports:
//   clk   in  1      clock, all state on posedge
//   init  in  1      synchronous active-high reset to INIT_PATTERN
//   en    in  1      advance one step
//   mode  in  2      RING / JOHNSON / SHIFT (fill 0) / HOLD
//   dir   in  1      0 = left (toward MSB), 1 = right (toward LSB)
//   load  in  1      synchronous parallel load of din
//   din   in  WIDTH  load value
//   count out WIDTH  register state
//   tc    out 1      one-cycle terminal-count pulse
//   err   out 1      one-cycle illegal-state pulse
//
// Build option: SELF_CORRECT_EN -- in RING mode a non-one-hot register is
// replaced by INIT_PATTERN on the next enabled step and err pulses; without
// it err is constant 0 and illegal patterns rotate unchanged.
module ring_counter_gen
  import rc_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] INIT_PATTERN = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             init,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             err
);

  localparam int SW = $clog2(2 * WIDTH);
  localparam logic [SW-1:0] RING_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] JOHN_LAST = SW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] count_q, count_n, adv;
  logic [SW-1:0]    step_q, step_n, last;
  logic [1:0]       mode_q, mode_n;
  logic             tc_q, tc_n;
  logic             err_q, err_n;
  logic             mode_chg;

`ifdef SELF_CORRECT_EN
  logic is_onehot;

  onehot_chk #(.WIDTH(WIDTH)) u_onehot_chk (
    .value     (count_q),
    .is_onehot (is_onehot)
  );
`endif

  // Candidate next value for an enabled step in the requested mode/direction.
  always_comb begin
    adv = count_q;
    case (mode)
      MODE_RING:    adv = (dir == DIR_RIGHT) ? {count_q[0], count_q[WIDTH-1:1]}
                                             : {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      MODE_JOHNSON: adv = (dir == DIR_RIGHT) ? {~count_q[0], count_q[WIDTH-1:1]}
                                             : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      MODE_SHIFT:   adv = (dir == DIR_RIGHT) ? {1'b0, count_q[WIDTH-1:1]}
                                             : {count_q[WIDTH-2:0], 1'b0};
      default:      adv = count_q;
    endcase
  end

  // Next-state selection below init (init is applied in the register block).
  always_comb begin
    count_n  = count_q;
    step_n   = step_q;
    mode_n   = mode_q;
    tc_n     = 1'b0;
    err_n    = 1'b0;
    mode_chg = (mode != mode_q);
    last     = (mode == MODE_RING) ? RING_LAST : JOHN_LAST;

    if (load) begin
      count_n = din;
      step_n  = '0;
    end else if (en) begin
      // mode_q tracks the mode of the last enabled step, so a change made
      // while idle is still seen on the next enabled step.
      mode_n = mode;
`ifdef SELF_CORRECT_EN
      if ((mode == MODE_RING) && !is_onehot) begin
        count_n = INIT_PATTERN;
        step_n  = '0;
        err_n   = 1'b1;
      end else
`endif
      begin
        count_n = adv;
        case (mode)
          MODE_RING, MODE_JOHNSON: begin
            // A mode switch restarts the period; this step is step 0->1.
            if (mode_chg) begin
              step_n = SW'(1);
            end else if (step_q == last) begin
              step_n = '0;
              tc_n   = 1'b1;
            end else begin
              step_n = step_q + SW'(1);
            end
          end
          MODE_SHIFT: begin
            if (mode_chg) step_n = '0;
            else          tc_n   = (count_q != '0) && (adv == '0);
          end
          default: begin
            if (mode_chg) step_n = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      count_q <= INIT_PATTERN;
      step_q  <= '0;
      mode_q  <= mode;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_n;
      step_q  <= step_n;
      mode_q  <= mode_n;
      tc_q    <= tc_n;
      err_q   <= err_n;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Self-checking bench for ring_counter_gen (WIDTH=8, INIT_PATTERN=8'h80).
// Each driven cycle pushes its expected outputs; the observed outputs are
// captured 1 time unit after the clock edge and the scenario task compares both.
module tb_ring_counter_gen;
  import rc_pkg::*;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       init = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [1:0] mode = MODE_RING;
  logic [7:0] din = 8'h00;
  logic [7:0] count;
  logic       tc, err;

  res_t exp_q[$];
  res_t obs_q[$];
  res_t e, o;
  logic [7:0] mc;
  int checks = 0;
  int errors = 0;

  ring_counter_gen #(.WIDTH(8), .INIT_PATTERN(8'h80)) dut (
    .clk   (clk),
    .init  (init),
    .en    (en),
    .mode  (mode),
    .dir   (dir),
    .load  (load),
    .din   (din),
    .count (count),
    .tc    (tc),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Reference step function for the register value.
  function automatic logic [7:0] nxt(input logic [7:0] c, input logic [1:0] m, input logic d);
    case (m)
      MODE_RING:    return d ? {c[0], c[7:1]}  : {c[6:0], c[7]};
      MODE_JOHNSON: return d ? {~c[0], c[7:1]} : {c[6:0], ~c[7]};
      MODE_SHIFT:   return d ? (c >> 1)        : (c << 1);
      default:      return c;
    endcase
  endfunction

  function automatic res_t mk(input logic [7:0] c, input logic t, input logic r);
    res_t x;
    x.count = c;
    x.tc    = t;
    x.err   = r;
    return x;
  endfunction

  task automatic drive(input logic i_init, input logic i_load, input logic i_en,
                       input logic [1:0] i_mode, input logic i_dir,
                       input logic [7:0] i_din, input res_t ex);
    init = i_init;
    load = i_load;
    en   = i_en;
    mode = i_mode;
    dir  = i_dir;
    din  = i_din;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    obs_q.push_back(mk(count, tc, err));
  endtask

  task automatic test_reset();
    drive(1, 0, 0, MODE_RING, DIR_LEFT, 8'h00, mk(8'h80, 0, 0));
    drive(0, 0, 0, MODE_RING, DIR_LEFT, 8'h00, mk(8'h80, 0, 0));
    mc = 8'h80;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  task automatic test_ring_left();
    for (int i = 0; i < 8; i++) begin
      mc = nxt(mc, MODE_RING, DIR_LEFT);
      drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, i == 7, 0));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ring_left[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  task automatic test_johnson();
    drive(0, 1, 0, MODE_RING, DIR_LEFT, 8'h00, mk(8'h00, 0, 0));
    mc = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mc = nxt(mc, MODE_JOHNSON, DIR_LEFT);
      drive(0, 0, 1, MODE_JOHNSON, DIR_LEFT, 8'h00, mk(mc, i == 15, 0));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL johnson[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  // Right steps with an idle gap, then a direction flip: tc lands on the 8th step overall.
  task automatic test_dir_change();
    drive(1, 0, 0, MODE_RING, DIR_LEFT, 8'h00, mk(8'h80, 0, 0));
    drive(0, 0, 1, MODE_RING, DIR_RIGHT, 8'h00, mk(8'h40, 0, 0));
    drive(0, 0, 0, MODE_RING, DIR_RIGHT, 8'h00, mk(8'h40, 0, 0));
    drive(0, 0, 1, MODE_RING, DIR_RIGHT, 8'h00, mk(8'h20, 0, 0));
    drive(0, 0, 1, MODE_RING, DIR_RIGHT, 8'h00, mk(8'h10, 0, 0));
    mc = 8'h10;
    for (int i = 0; i < 5; i++) begin
      mc = nxt(mc, MODE_RING, DIR_LEFT);
      drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, i == 4, 0));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dir_change[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 1, MODE_RING, DIR_LEFT, 8'h81, mk(8'h81, 0, 0));
`ifdef SELF_CORRECT_EN
    mc = 8'h80;
    drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, 0, 1));
`else
    mc = 8'h03;
    drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, 0, 0));
`endif
    drive(0, 0, 0, MODE_RING, DIR_LEFT, 8'h00, mk(mc, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_priority[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  task automatic test_init_priority();
    for (int i = 0; i < 3; i++) begin
      mc = nxt(mc, MODE_RING, DIR_LEFT);
      drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, 0, 0));
    end
    drive(1, 1, 1, MODE_RING, DIR_LEFT, 8'h55, mk(8'h80, 0, 0));
    mc = 8'h80;
    for (int i = 0; i < 8; i++) begin
      mc = nxt(mc, MODE_RING, DIR_LEFT);
      drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, i == 7, 0));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL init_priority[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  task automatic test_shift_hold();
    drive(1, 0, 0, MODE_SHIFT, DIR_LEFT, 8'h00, mk(8'h80, 0, 0));
    drive(0, 0, 1, MODE_SHIFT, DIR_LEFT, 8'h00, mk(8'h00, 1, 0));
    drive(0, 0, 1, MODE_SHIFT, DIR_LEFT, 8'h00, mk(8'h00, 0, 0));
    drive(0, 0, 1, MODE_HOLD,  DIR_LEFT, 8'h00, mk(8'h00, 0, 0));
    drive(1, 0, 0, MODE_SHIFT, DIR_RIGHT, 8'h00, mk(8'h80, 0, 0));
    mc = 8'h80;
    for (int i = 0; i < 8; i++) begin
      mc = nxt(mc, MODE_SHIFT, DIR_RIGHT);
      drive(0, 0, 1, MODE_SHIFT, DIR_RIGHT, 8'h00, mk(mc, i == 7, 0));
    end
    drive(0, 0, 1, MODE_HOLD, DIR_RIGHT, 8'h00, mk(8'h00, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL shift_hold[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  // Three RING steps, then a switch to JOHNSON: the period restarts at the switch.
  task automatic test_mode_change();
    drive(1, 0, 0, MODE_RING, DIR_LEFT, 8'h00, mk(8'h80, 0, 0));
    mc = 8'h80;
    for (int i = 0; i < 3; i++) begin
      mc = nxt(mc, MODE_RING, DIR_LEFT);
      drive(0, 0, 1, MODE_RING, DIR_LEFT, 8'h00, mk(mc, 0, 0));
    end
    for (int i = 0; i < 16; i++) begin
      mc = nxt(mc, MODE_JOHNSON, DIR_LEFT);
      drive(0, 0, 1, MODE_JOHNSON, DIR_LEFT, 8'h00, mk(mc, i == 15, 0));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mode_change[%0d]: got count=%h tc=%b err=%b, want count=%h tc=%b err=%b",
                 i, o.count, o.tc, o.err, e.count, e.tc, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_left();
    test_johnson();
    test_dir_change();
    test_load_priority();
    test_init_priority();
    test_shift_hold();
    test_mode_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
